// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM encoding, frame header constant and width helpers for the UART TX arbiter.
package uart_tx_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  function automatic int bytes_per_word(input int nbits_d, input int dbit);
    return nbits_d / dbit;
  endfunction

  // Index width that stays legal (>= 1 bit) even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle between the arbiter (slave) and its environment (master).
interface uart_tx_arbiter_if #(
  parameter int NREQ    = 2,
  parameter int NBITS_D = 16,
  parameter int DBIT    = 8
) ();
  import uart_tx_arbiter_pkg::*;

  localparam int OW = idx_width(NREQ);

  logic [NREQ-1:0]         i_req;
  logic [NREQ*NBITS_D-1:0] i_data;
  logic [NREQ-1:0]         o_grant;
  logic                    o_tx_start;
  logic [DBIT-1:0]         o_tx_data;
  logic                    i_tx_done;
  logic                    o_busy;
  logic [OW-1:0]           o_owner;

  modport master (
    output i_req, i_data, i_tx_done,
    input  o_grant, o_tx_start, o_tx_data, o_busy, o_owner
  );

  modport slave (
    input  i_req, i_data, i_tx_done,
    output o_grant, o_tx_start, o_tx_data, o_busy, o_owner
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr wins, one-hot out.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int PW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            vld
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter among NREQ word requesters, round-robin, LSB byte first.
// Define UART_TX_ARBITER_FRAME_EN to prefix each word with header byte {4'hA, owner}.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int NBITS_D = 16,
  parameter int DBIT    = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int OW    = idx_width(NREQ);
  localparam int BYTES = bytes_per_word(NBITS_D, DBIT);
`ifdef UART_TX_ARBITER_FRAME_EN
  localparam int NFRAME = BYTES + 1;
`else
  localparam int NFRAME = BYTES;
`endif
  localparam int FW = NFRAME * DBIT;
  localparam int CW = idx_width(NFRAME);

  state_t          state_q;
  logic [OW-1:0]   rr_ptr_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [FW-1:0]   frame_q;
  logic [NREQ-1:0] grant_q;
  logic            tx_start_q;
  logic [DBIT-1:0] tx_data_q;
  logic            busy_q;
  logic [OW-1:0]   owner_q;

  logic [NREQ-1:0]    arb_gnt;
  logic               arb_vld;
  logic [OW-1:0]      win_idx;
  logic [NBITS_D-1:0] win_word;
  logic [FW-1:0]      frame_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (bus.i_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    win_idx  = '0;
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_idx  = OW'(i);
        win_word = bus.i_data[i*NBITS_D +: NBITS_D];
      end
    end
  end

  // The frame register holds exactly the byte sequence to send, header in the low byte.
`ifdef UART_TX_ARBITER_FRAME_EN
  assign frame_d = {win_word, HDR_NIBBLE, (DBIT-4)'(win_idx)};
`else
  assign frame_d = win_word;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      frame_q    <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
    end else begin
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            frame_q    <= frame_d;
            grant_q    <= arb_gnt;
            owner_q    <= win_idx;
            rr_ptr_q   <= (win_idx == OW'(NREQ-1)) ? '0 : win_idx + 1'b1;
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          tx_start_q <= 1'b1;
          tx_data_q  <= frame_q[byte_cnt_q*DBIT +: DBIT];
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_tx_done) begin
            if (byte_cnt_q == CW'(NFRAME-1)) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= ST_SEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_owner    = owner_q;

endmodule
